pc_sequencer: RTL

- Parametrised next-generation program counter for the single-cycle/pipelined datapath; sits in front of instruction memory.
- Holds the current fetch address and selects the next one from sequential, branch, jump, call or return.
- Adds stall, configurable reset vector and a circular return-address stack (RAS).
- Overflow/underflow flags are exposed for debug.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer_ras_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared select encoding and default constants for the PC sequencer
package pc_pkg;

  localparam int          PC_WIDTH = 32;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  // Fixed priority among the control-flow requests; stall is handled by the caller.
  function automatic pc_sel_e pc_select(input logic ret, input logic call,
                                        input logic jump, input logic br);
    if (ret)       return SEL_RET;
    else if (call) return SEL_CALL;
    else if (jump) return SEL_JMP;
    else if (br)   return SEL_BR;
    else           return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control and status bundle between fetch control and the PC sequencer
interface pc_sequencer_if import pc_pkg::*; #(
  parameter int WIDTH = PC_WIDTH
) ();

  logic             Stall;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             Jump;
  logic             Call;
  logic             Ret;
  logic [WIDTH-1:0] JumpTarget;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlus;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasOverflow;
  logic             RasUnderflow;

  modport master (
    output Stall, BranchTaken, BranchTarget, Jump, Call, Ret, JumpTarget,
    input  PCResult, PCPlus, RasEmpty, RasFull, RasOverflow, RasUnderflow
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, Jump, Call, Ret, JumpTarget,
    output PCResult, PCPlus, RasEmpty, RasFull, RasOverflow, RasUnderflow
  );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// rtl/pc_sequencer_ras_stack.sv - circular return-address LIFO; a push when full overwrites the oldest entry
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign ptr_inc = ptr_q + 1'b1;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_o   = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_inc;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; only the pointer and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[ptr_inc] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with stall, branch/jump/call/return select and debug RAS flags
module pc_sequencer import pc_pkg::*; #(
  parameter int               WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned      INC        = PC_INC,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  pc_sequencer_if.slave bus
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d, pc_plus, ras_top;
  logic             ras_push, ras_pop, ras_empty, ras_full;
  logic             ovf_q, ovf_d, udf_q, udf_d;

  assign pc_plus = pc_q + WIDTH'(INC);
  assign sel     = pc_select(bus.Ret, bus.Call, bus.Jump, bus.BranchTaken);

  always_comb begin
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!bus.Stall) begin
      case (sel)
        SEL_RET: begin
          // Returning with nothing saved falls through to the next sequential address.
          if (ras_empty) begin
            pc_d  = pc_plus;
            udf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        SEL_CALL: begin
          pc_d     = bus.JumpTarget;
          ras_push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
        end
        SEL_JMP: pc_d = bus.JumpTarget;
        SEL_BR:  pc_d = bus.BranchTarget;
        default: pc_d = pc_plus;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

  assign bus.PCResult     = pc_q;
  assign bus.PCPlus       = pc_plus;
  assign bus.RasEmpty     = ras_empty;
  assign bus.RasFull      = ras_full;
  assign bus.RasOverflow  = ovf_q;
  assign bus.RasUnderflow = udf_q;

endmodule
